// File: rtl/mybusmatrix5x7_in_hold.sv
// Master-side input stage of the 5x7 bus matrix: holds an AHB-Lite address phase
// that the output stage cannot take yet, and routes the data-phase response back.
module mybusmatrix5x7_in_hold #(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  HCLK,
    input  logic                  HRESET,
    input  logic                  HSELS,
    input  logic [ADDR_WIDTH-1:0] HADDRS,
    input  logic [1:0]            HTRANSS,
    input  logic                  HWRITES,
    input  logic [2:0]            HSIZES,
    input  logic [2:0]            HBURSTS,
    input  logic [3:0]            HPROTS,
    input  logic                  HMASTLOCKS,
    input  logic                  HREADYS,
    input  logic                  addr_accept,
    input  logic                  readyout_dec,
    input  logic [1:0]            resp_dec,
    output logic                  HREADYOUTS,
    output logic                  HRESPS,
    output logic [ADDR_WIDTH-1:0] HADDRI,
    output logic [1:0]            HTRANSI,
    output logic                  HWRITEI,
    output logic [2:0]            HSIZEI,
    output logic [2:0]            HBURSTI,
    output logic [3:0]            HPROTI,
    output logic                  HMASTLOCKI,
    output logic                  trans_pend
);

    logic                  r_pend;
    logic                  r_dphase;
    logic [ADDR_WIDTH-1:0] r_hold_addr;
    logic [1:0]            r_hold_trans;
    logic                  r_hold_write;
    logic [2:0]            r_hold_size;
    logic [2:0]            r_hold_burst;
    logic [3:0]            r_hold_prot;
    logic                  r_hold_lock;

    logic w_new_tx;
    logic w_pend_nxt;
    logic w_dphase_nxt;
    logic w_unused_resp_hi;

    // Only NONSEQ/SEQ (HTRANS[1]=1) qualified by select and HREADY is a real transfer.
    assign w_new_tx         = HSELS & HREADYS & HTRANSS[1];
    assign w_unused_resp_hi = resp_dec[1];

    // Pending and data-phase next-state decode.
    always_comb begin
        w_pend_nxt   = r_pend;
        w_dphase_nxt = r_dphase;
        if (w_new_tx && !addr_accept) begin
            w_pend_nxt = 1'b1;
        end else if (r_pend && addr_accept) begin
            w_pend_nxt = 1'b0;
        end else begin
            w_pend_nxt = r_pend;
        end
        if (addr_accept) begin
            w_dphase_nxt = 1'b1;
        end else if (r_dphase && readyout_dec) begin
            w_dphase_nxt = 1'b0;
        end else begin
            w_dphase_nxt = r_dphase;
        end
    end

    // Control state registers.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            r_pend   <= 1'b0;
            r_dphase <= 1'b0;
        end else begin
            r_pend   <= w_pend_nxt;
            r_dphase <= w_dphase_nxt;
        end
    end

    // Hold copy of the address phase; frozen while a request is outstanding.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            r_hold_addr  <= {ADDR_WIDTH{1'b0}};
            r_hold_trans <= 2'b00;
            r_hold_write <= 1'b0;
            r_hold_size  <= 3'b000;
            r_hold_burst <= 3'b000;
            r_hold_prot  <= 4'b0000;
            r_hold_lock  <= 1'b0;
        end else if (w_new_tx && !r_pend) begin
            r_hold_addr  <= HADDRS;
            r_hold_trans <= HTRANSS;
            r_hold_write <= HWRITES;
            r_hold_size  <= HSIZES;
            r_hold_burst <= HBURSTS;
            r_hold_prot  <= HPROTS;
            r_hold_lock  <= HMASTLOCKS;
        end else begin
            r_hold_addr  <= r_hold_addr;
            r_hold_trans <= r_hold_trans;
            r_hold_write <= r_hold_write;
            r_hold_size  <= r_hold_size;
            r_hold_burst <= r_hold_burst;
            r_hold_prot  <= r_hold_prot;
            r_hold_lock  <= r_hold_lock;
        end
    end

    // Address-phase mux toward the decoder and master-facing response.
    always_comb begin
        trans_pend = r_pend | w_new_tx;
        if (r_pend) begin
            HADDRI     = r_hold_addr;
            HTRANSI    = r_hold_trans;
            HWRITEI    = r_hold_write;
            HSIZEI     = r_hold_size;
            HBURSTI    = r_hold_burst;
            HPROTI     = r_hold_prot;
            HMASTLOCKI = r_hold_lock;
            HREADYOUTS = 1'b0;
            HRESPS     = 1'b0;
        end else begin
            HADDRI     = HADDRS;
            HTRANSI    = HTRANSS;
            HWRITEI    = HWRITES;
            HSIZEI     = HSIZES;
            HBURSTI    = HBURSTS;
            HPROTI     = HPROTS;
            HMASTLOCKI = HMASTLOCKS;
            if (r_dphase) begin
                HREADYOUTS = readyout_dec;
                HRESPS     = resp_dec[0];
            end else begin
                HREADYOUTS = 1'b1;
                HRESPS     = 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mybusmatrix5x7_in_hold.sv
// Self-checking bench for mybusmatrix5x7_in_hold: directed scenarios followed by
// random traffic, compared against a transaction-level reference model.
module tb_mybusmatrix5x7_in_hold;

    localparam int AW = 32;

    logic          HCLK = 1'b0;
    logic          HRESET;
    logic          HSELS;
    logic [AW-1:0] HADDRS;
    logic [1:0]    HTRANSS;
    logic          HWRITES;
    logic [2:0]    HSIZES;
    logic [2:0]    HBURSTS;
    logic [3:0]    HPROTS;
    logic          HMASTLOCKS;
    logic          HREADYS;
    logic          addr_accept;
    logic          readyout_dec;
    logic [1:0]    resp_dec;
    logic          HREADYOUTS;
    logic          HRESPS;
    logic [AW-1:0] HADDRI;
    logic [1:0]    HTRANSI;
    logic          HWRITEI;
    logic [2:0]    HSIZEI;
    logic [2:0]    HBURSTI;
    logic [3:0]    HPROTI;
    logic          HMASTLOCKI;
    logic          trans_pend;

    int checks = 0;
    int errors = 0;

    always #5 HCLK = ~HCLK;

    mybusmatrix5x7_in_hold #(.ADDR_WIDTH(AW)) dut (
        .HCLK(HCLK), .HRESET(HRESET), .HSELS(HSELS), .HADDRS(HADDRS),
        .HTRANSS(HTRANSS), .HWRITES(HWRITES), .HSIZES(HSIZES), .HBURSTS(HBURSTS),
        .HPROTS(HPROTS), .HMASTLOCKS(HMASTLOCKS), .HREADYS(HREADYS),
        .addr_accept(addr_accept), .readyout_dec(readyout_dec), .resp_dec(resp_dec),
        .HREADYOUTS(HREADYOUTS), .HRESPS(HRESPS), .HADDRI(HADDRI), .HTRANSI(HTRANSI),
        .HWRITEI(HWRITEI), .HSIZEI(HSIZEI), .HBURSTI(HBURSTI), .HPROTI(HPROTI),
        .HMASTLOCKI(HMASTLOCKI), .trans_pend(trans_pend)
    );

    // Reference model: an outstanding (waiting) address phase, if any, and
    // whether a transfer is currently in its data phase.
    typedef struct packed {
        logic [AW-1:0] addr;
        logic [1:0]    trans;
        logic          write;
        logic [2:0]    size;
        logic [2:0]    burst;
        logic [3:0]    prot;
        logic          lock;
    } aphase_t;

    bit      m_waiting;
    bit      m_in_data;
    aphase_t m_saved;

    function automatic aphase_t live_phase();
        aphase_t a;
        a.addr = HADDRS; a.trans = HTRANSS; a.write = HWRITES; a.size = HSIZES;
        a.burst = HBURSTS; a.prot = HPROTS; a.lock = HMASTLOCKS;
        return a;
    endfunction

    function automatic bit is_transfer();
        return HSELS && HREADYS && (HTRANSS == 2'b10 || HTRANSS == 2'b11);
    endfunction

    function automatic bit exp_ready();
        if (m_waiting) return 1'b0;
        if (m_in_data) return readyout_dec;
        return 1'b1;
    endfunction

    function automatic bit exp_resp();
        if (m_waiting) return 1'b0;
        if (m_in_data) return (resp_dec == 2'b01 || resp_dec == 2'b11);
        return 1'b0;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Check every output against the model midway through the cycle.
    task automatic sample(input string tag);
        aphase_t a;
        aphase_t o;
        @(negedge HCLK);
        a = m_waiting ? m_saved : live_phase();
        o = '{HADDRI, HTRANSI, HWRITEI, HSIZEI, HBURSTI, HPROTI, HMASTLOCKI};
        chk({tag, "_aphase"}, 64'(o), 64'(a));
        chk({tag, "_readyout"}, 64'(HREADYOUTS), 64'(exp_ready()));
        chk({tag, "_resp"}, 64'(HRESPS), 64'(exp_resp()));
        chk({tag, "_trans_pend"}, 64'(trans_pend), 64'(m_waiting || is_transfer()));
    endtask

    // Advance one clock and update the model from the inputs of that cycle.
    task automatic advance();
        bit tx;
        @(posedge HCLK);
        tx = is_transfer();
        if (HRESET) begin
            m_waiting = 1'b0;
            m_in_data = 1'b0;
            m_saved   = '0;
        end else begin
            if (addr_accept) m_in_data = 1'b1;
            else if (m_in_data && readyout_dec) m_in_data = 1'b0;
            if (tx && !m_waiting) m_saved = live_phase();
            if (tx && !addr_accept) m_waiting = 1'b1;
            else if (m_waiting && addr_accept) m_waiting = 1'b0;
        end
        #1;
    endtask

    task automatic cycle(input string tag);
        sample(tag);
        advance();
    endtask

    task automatic drive_idle();
        HRESET = 1'b0; HSELS = 1'b0; HADDRS = '0; HTRANSS = 2'b00; HWRITES = 1'b0;
        HSIZES = 3'd0; HBURSTS = 3'd0; HPROTS = 4'd0; HMASTLOCKS = 1'b0; HREADYS = 1'b1;
        addr_accept = 1'b0; readyout_dec = 1'b1; resp_dec = 2'b00;
    endtask

    task automatic drive_nonseq(input logic [AW-1:0] a);
        HSELS = 1'b1; HADDRS = a; HTRANSS = 2'b10; HWRITES = 1'b1;
        HSIZES = 3'd2; HBURSTS = 3'd0; HPROTS = 4'h3; HMASTLOCKS = 1'b0; HREADYS = 1'b1;
    endtask

    initial begin
        drive_idle();
        HRESET = 1'b1;
        advance();
        HRESET = 1'b0;
        sample("reset");
        chk("reset_readyout", 64'(HREADYOUTS), 64'd1);
        chk("reset_trans_pend", 64'(trans_pend), 64'd0);
        advance();

        // 1: accepted in the same cycle
        drive_nonseq(32'h2000_0010); addr_accept = 1'b1;
        sample("t1_addr");
        chk("t1_haddri", 64'(HADDRI), 64'h2000_0010);
        advance();
        drive_idle(); readyout_dec = 1'b0;
        sample("t1_data");
        chk("t1_readyout_follows", 64'(HREADYOUTS), 64'd0);
        readyout_dec = 1'b1;
        cycle("t1_done");

        // 2: held for two cycles, accepted on the third
        drive_nonseq(32'h4000_0000);
        cycle("t2_issue");
        drive_nonseq(32'hDEAD_BEEF); HREADYS = 1'b0;
        for (int i = 0; i < 2; i++) begin
            sample("t2_hold");
            chk("t2_haddri_held", 64'(HADDRI), 64'h4000_0000);
            chk("t2_readyout_stall", 64'(HREADYOUTS), 64'd0);
            chk("t2_trans_pend", 64'(trans_pend), 64'd1);
            advance();
        end
        addr_accept = 1'b1;
        sample("t2_accept");
        chk("t2_haddri_accept", 64'(HADDRI), 64'h4000_0000);
        advance();
        drive_idle();
        sample("t2_after");
        chk("t2_trans_pend_clear", 64'(trans_pend), 64'd0);
        advance();

        // 3: data phase with three wait states
        drive_nonseq(32'h1000_0040); addr_accept = 1'b1;
        cycle("t3_addr");
        drive_idle(); readyout_dec = 1'b0;
        for (int i = 0; i < 3; i++) begin
            sample("t3_wait");
            chk("t3_readyout_low", 64'(HREADYOUTS), 64'd0);
            advance();
        end
        readyout_dec = 1'b1;
        cycle("t3_last");
        readyout_dec = 1'b0;
        sample("t3_cleared");
        chk("t3_dphase_cleared", 64'(HREADYOUTS), 64'd1);
        advance();

        // 4: two-cycle ERROR response with a transfer held across it
        drive_nonseq(32'h3000_0000); addr_accept = 1'b1;
        cycle("t4_addr");
        drive_idle(); readyout_dec = 1'b0; resp_dec = 2'b01;
        drive_nonseq(32'h3000_0100); HREADYS = 1'b1;
        sample("t4_err1");
        chk("t4_resp1", 64'(HRESPS), 64'd1);
        chk("t4_ready1", 64'(HREADYOUTS), 64'd0);
        advance();
        drive_idle(); readyout_dec = 1'b1; resp_dec = 2'b01; HREADYS = 1'b0;
        sample("t4_err2");
        chk("t4_held_resp_masked", 64'(HRESPS), 64'd0);
        addr_accept = 1'b1;
        advance();
        drive_idle();
        cycle("t4_issue_data");

        // 5: reset while pending
        drive_nonseq(32'h5000_0000);
        cycle("t5_issue");
        drive_idle(); HRESET = 1'b1; HREADYS = 1'b0;
        cycle("t5_reset");
        drive_idle(); readyout_dec = 1'b0;
        sample("t5_after");
        chk("t5_readyout", 64'(HREADYOUTS), 64'd1);
        chk("t5_trans_pend", 64'(trans_pend), 64'd0);
        advance();

        // 6: IDLE and BUSY are never held
        for (int t = 0; t < 2; t++) begin
            drive_nonseq(32'h6000_0000); HTRANSS = 2'(t);
            cycle("t6_live");
            drive_idle();
            sample("t6_next");
            chk("t6_readyout", 64'(HREADYOUTS), 64'd1);
            chk("t6_trans_pend", 64'(trans_pend), 64'd0);
            advance();
        end

        // Random traffic: master sees the matrix HREADY, arbiter grants only requests.
        for (int n = 0; n < 400; n++) begin
            HRESET     = ($urandom_range(0, 59) == 0);
            HSELS      = 1'($urandom_range(0, 3) != 0);
            HADDRS     = $urandom;
            HTRANSS    = 2'($urandom);
            HWRITES    = 1'($urandom);
            HSIZES     = 3'($urandom);
            HBURSTS    = 3'($urandom);
            HPROTS     = 4'($urandom);
            HMASTLOCKS = 1'($urandom);
            readyout_dec = 1'($urandom_range(0, 2) != 0);
            resp_dec   = 2'($urandom);
            HREADYS    = exp_ready();
            addr_accept = (m_waiting || is_transfer()) && ($urandom_range(0, 2) == 0);
            cycle("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
